// File: rtl/gzip_member_sequencer.sv
// gzip_member_sequencer: wraps a deflate byte stream in a GZIP member (10-byte header, body, CRC32/ISIZE trailer).
// Optional GZIP_SEQ_STATS_EN adds out_byte_count, the number of output transfers since the last start.
module gzip_member_sequencer #(
   parameter logic [7:0] OS_ID   = 8'h03,
   parameter logic [7:0] XFL_VAL = 8'h00
) (
   input  logic        core_clock,
   input  logic        rst_n,
   input  logic        start,
   input  logic        raw_byte_stb,
   input  logic [7:0]  enc_data,
   input  logic        enc_valid,
   input  logic        enc_last,
   output logic        enc_ready,
   input  logic [31:0] crc_value,
   input  logic        crc_done,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_eof,
   output logic        busy,
`ifdef GZIP_SEQ_STATS_EN
   output logic [31:0] out_byte_count,
`endif
   output logic        done
);
   typedef enum logic [2:0] {IDLE, HEADER, BODY, WAIT_CRC, TRAILER} state_t;
   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [31:0] isize_q, isize_d;
   logic [63:0] trl_q, trl_d;
   logic        done_q, done_d;
   logic [7:0]  hdr_byte, trl_byte;
   logic        xfer, cnt_en;
   assign hdr_byte = (idx_q == 4'd0) ? 8'h1f :
                     (idx_q == 4'd1) ? 8'h8b :
                     (idx_q == 4'd2) ? 8'h08 :
                     (idx_q == 4'd8) ? XFL_VAL :
                     (idx_q == 4'd9) ? OS_ID : 8'h00;
   // trailer is held as {isize, crc} so byte idx is simply the idx-th byte, LSB first
   assign trl_byte  = trl_q[{idx_q[2:0], 3'b000} +: 8];
   assign out_valid = (state_q == HEADER) || (state_q == TRAILER) || ((state_q == BODY) && enc_valid);
   assign out_data  = (state_q == HEADER)  ? hdr_byte :
                      (state_q == BODY)    ? enc_data :
                      (state_q == TRAILER) ? trl_byte : 8'h00;
   assign out_eof   = (state_q == TRAILER) && (idx_q == 4'd7);
   assign enc_ready = (state_q == BODY) && out_ready;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign xfer      = out_valid && out_ready;
   assign cnt_en    = raw_byte_stb && ((state_q == HEADER) || (state_q == BODY) || (state_q == WAIT_CRC));
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      isize_d = cnt_en ? isize_q + 32'd1 : isize_q;
      trl_d   = trl_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = HEADER;
            idx_d   = 4'd0;
            isize_d = 32'd0;
         end
         HEADER: if (xfer) begin
            idx_d   = (idx_q == 4'd9) ? 4'd0 : idx_q + 4'd1;
            state_d = (idx_q == 4'd9) ? BODY : HEADER;
         end
         BODY: if (xfer && enc_last) state_d = WAIT_CRC;
         WAIT_CRC: if (crc_done) begin
            state_d = TRAILER;
            idx_d   = 4'd0;
            trl_d   = {isize_d, crc_value};
         end
         TRAILER: if (xfer) begin
            idx_d   = (idx_q == 4'd7) ? 4'd0 : idx_q + 4'd1;
            state_d = (idx_q == 4'd7) ? IDLE : TRAILER;
            done_d  = (idx_q == 4'd7);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge core_clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         isize_q <= 32'd0;
         trl_q   <= 64'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         isize_q <= isize_d;
         trl_q   <= trl_d;
         done_q  <= done_d;
      end
   end
`ifdef GZIP_SEQ_STATS_EN
   logic [31:0] obc_q, obc_d;
   assign obc_d = ((state_q == IDLE) && start) ? 32'd0 : xfer ? obc_q + 32'd1 : obc_q;
   assign out_byte_count = obc_q;
   always_ff @(posedge core_clock or negedge rst_n) begin
      if (!rst_n) obc_q <= 32'd0;
      else        obc_q <= obc_d;
   end
`endif
endmodule

// File: tb/tb_gzip_member_sequencer.sv
// tb_gzip_member_sequencer: directed member framing checks against a byte scoreboard.
module tb_gzip_member_sequencer;
   logic        core_clock = 1'b0;
   logic        rst_n = 1'b0, start = 1'b0, raw_byte_stb = 1'b0;
   logic [7:0]  enc_data = 8'h00;
   logic        enc_valid = 1'b0, enc_last = 1'b0, enc_ready;
   logic [31:0] crc_value = 32'h0;
   logic        crc_done = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid, out_ready, out_eof, busy, done;
   logic        rdy = 1'b1, bp = 1'b0, tog = 1'b0;
`ifdef GZIP_SEQ_STATS_EN
   logic [31:0] out_byte_count;
`endif
   logic [8:0]  sb[$];
   logic [8:0]  held, exp_b;
   logic        stall = 1'b0;
   logic [7:0]  lb[3];
   int          total = 0, bad = 0;

   always #5 core_clock = ~core_clock;
   assign out_ready = bp ? tog : rdy;
   initial forever begin
      @(posedge core_clock);
      #1 tog = ~tog;
   end

   gzip_member_sequencer dut (
      .core_clock(core_clock), .rst_n(rst_n), .start(start), .raw_byte_stb(raw_byte_stb),
      .enc_data(enc_data), .enc_valid(enc_valid), .enc_last(enc_last), .enc_ready(enc_ready),
      .crc_value(crc_value), .crc_done(crc_done), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_eof(out_eof), .busy(busy),
`ifdef GZIP_SEQ_STATS_EN
      .out_byte_count(out_byte_count),
`endif
      .done(done));

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   always @(negedge core_clock) begin
      if (!rst_n) stall <= 1'b0;
      else begin
         if (stall) chk("hold", {out_valid, out_eof, out_data}, {1'b1, held});
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("extra_byte", {out_eof, out_data}, 9'h1ff);
            else begin
               exp_b = sb.pop_front();
               chk("out_byte", {out_eof, out_data}, exp_b);
            end
         end
         stall <= out_valid && !out_ready;
         held  <= {out_eof, out_data};
      end
   end

   task automatic tick();
      @(posedge core_clock);
      #1;
   endtask

   task automatic push_member(input logic [7:0] b0, b1, b2, input int n, input logic [31:0] crc, isz);
      logic [7:0]  hdr[10];
      logic [63:0] t;
      hdr = '{8'h1f, 8'h8b, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
      lb  = '{b0, b1, b2};
      t   = {isz, crc};
      for (int i = 0; i < 10; i++) sb.push_back({1'b0, hdr[i]});
      for (int i = 0; i < n; i++) sb.push_back({1'b0, lb[i]});
      for (int i = 0; i < 8; i++) sb.push_back({i == 7, t[i*8 +: 8]});
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic strobe(input int n);
      raw_byte_stb = 1'b1;
      repeat (n) tick();
      raw_byte_stb = 1'b0;
   endtask

   task automatic send_enc(input logic [7:0] b, input logic last);
      bit ok = 0;
      enc_data = b; enc_valid = 1'b1; enc_last = last;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge core_clock);
         if (enc_ready) begin
            tick();
            ok = 1;
         end
      end
      if (!ok) chk("enc_timeout", 0, 1);
      enc_valid = 1'b0; enc_last = 1'b0;
   endtask

   task automatic run_body(input int n);
      for (int i = 0; i < n; i++) send_enc(lb[i], i == n - 1);
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge core_clock);
         ok = !busy;
      end
      if (!ok) chk("done_timeout", 0, 1);
      chk("done_pulse", done, 1);
      @(negedge core_clock);
      chk("done_clear", done, 0);
      chk("sb_empty", sb.size(), 0);
      tick();
   endtask

   initial begin
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_eof", out_eof, 0);
      tick();
      rst_n = 1'b1;
      tick();
      // T1/T2: header, 3-byte body, CRC already final, 5 raw bytes
      crc_value = 32'h12345678; crc_done = 1'b1;
      push_member(8'hAA, 8'hBB, 8'hCC, 3, 32'h12345678, 32'd5);
      start_pulse();
      chk("busy_hdr", busy, 1);
      chk("enc_ready_hdr", enc_ready, 0);
      strobe(5);
      run_body(3);
      wait_done();
`ifdef GZIP_SEQ_STATS_EN
      chk("byte_count_t2", out_byte_count, 32'd21);
`endif
      // T3: alternating backpressure
      bp = 1'b1;
      push_member(8'hAA, 8'hBB, 8'hCC, 3, 32'h12345678, 32'd5);
      start_pulse();
      strobe(5);
      run_body(3);
      wait_done();
      bp = 1'b0;
      // T4: single-byte body, CRC 20 cycles late, start ignored while waiting
      crc_done = 1'b0; crc_value = 32'hDEADBEEF;
      push_member(8'h03, 8'h00, 8'h00, 1, 32'hDEADBEEF, 32'd0);
      start_pulse();
      run_body(1);
      for (int i = 0; i < 20; i++) begin
         @(negedge core_clock);
         chk("wait_valid", out_valid, 0);
         chk("wait_busy", busy, 1);
         start = (i == 5);
      end
      start = 1'b0;
      tick();
      crc_done = 1'b1;
      wait_done();
      // T5: ISIZE wrap from FFFFFFFF with 3 strobes
      rdy = 1'b0; crc_value = 32'hCAFEF00D;
      push_member(8'h5A, 8'h00, 8'h00, 1, 32'hCAFEF00D, 32'd2);
      start_pulse();
      @(negedge core_clock);
      force dut.isize_q = 32'hFFFFFFFF;
      @(negedge core_clock);
      release dut.isize_q;
      strobe(3);
      rdy = 1'b1;
      run_body(1);
      wait_done();
      // T6: reset at trailer idx 3, then fresh member
      crc_value = 32'h11223344;
      push_member(8'h01, 8'h02, 8'h00, 2, 32'h11223344, 32'd0);
      start_pulse();
      run_body(2);
      for (int k = 0; k < 100 && sb.size() != 5; k++) tick();
      chk("t6_reach_idx3", sb.size(), 5);
      rst_n = 1'b0;
      #1;
      chk("t6_valid", out_valid, 0);
      chk("t6_data", out_data, 0);
      chk("t6_eof", out_eof, 0);
      chk("t6_busy", busy, 0);
      chk("t6_enc_ready", enc_ready, 0);
      sb.delete();
      repeat (3) begin
         @(negedge core_clock);
         chk("t6_no_done", done, 0);
      end
`ifdef GZIP_SEQ_STATS_EN
      chk("t6_count_rst", out_byte_count, 0);
`endif
      tick();
      rst_n = 1'b1;
      tick();
      crc_value = 32'h12345678;
      push_member(8'hAA, 8'hBB, 8'hCC, 3, 32'h12345678, 32'd5);
      start_pulse();
      strobe(5);
      run_body(3);
      wait_done();
`ifdef GZIP_SEQ_STATS_EN
      chk("byte_count_t6", out_byte_count, 32'd21);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
